// File: rtl/ysyx_25020047_ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM feeding a small
// instruction FIFO, with redirect flush and fault halt.
//
// state | meaning
// IDLE  | no request; waiting for a free FIFO slot
// REQ   | imem_req_valid high with fpc until accepted
// WAIT  | one request outstanding; response is pushed to the FIFO
// DROP  | one stale request outstanding; its response is discarded
// HALT  | fetch fault delivered; no requests until redirect
module ysyx_25020047_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic        out_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HALT} state_t;

   state_t        state;
   logic [31:0]   fpc;
   logic [31:0]   req_pc;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [CW-1:0] count_after;
   logic          push;
   logic          pop;

   logic [31:0] mem_inst [DEPTH];
   logic [31:0] mem_pc   [DEPTH];
   logic        mem_err  [DEPTH];

   assign push        = (state == WAIT) && imem_rsp_valid && !redirect;
   assign pop         = out_valid && out_ready && !redirect;
   assign count_after = pop ? count : count + CW'(1);

   assign imem_req_valid = (state == REQ);
   assign imem_req_addr  = fpc;
   assign out_valid      = (count != '0);
   assign out_inst       = out_valid ? mem_inst[head] : '0;
   assign out_pc         = out_valid ? mem_pc[head]   : '0;
   assign out_err        = out_valid ? mem_err[head]  : 1'b0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         fpc    <= RESET_PC;
         req_pc <= '0;
         head   <= '0;
         tail   <= '0;
         count  <= '0;
      end else if (redirect) begin
         // Flush wins over everything; an in-flight request turns into a drop.
         fpc   <= redirect_pc & ~32'd3;
         head  <= '0;
         tail  <= '0;
         count <= '0;
         case (state)
            REQ:     state <= imem_req_ready ? DROP : REQ;
            WAIT:    state <= imem_rsp_valid ? REQ : DROP;
            DROP:    state <= imem_rsp_valid ? REQ : DROP;
            default: state <= REQ;
         endcase
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (!push && pop)
            count <= count - CW'(1);
         case (state)
            IDLE: if (count < DEPTH_C) state <= REQ;
            REQ: begin
               if (imem_req_ready) begin
                  req_pc <= fpc;
                  fpc    <= fpc + 32'd4;
                  state  <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rsp_valid) begin
                  if (imem_rsp_err)
                     state <= HALT;
                  else if (count_after < DEPTH_C)
                     state <= REQ;
                  else
                     state <= IDLE;
               end
            end
            DROP: if (imem_rsp_valid) state <= REQ;
            default: state <= state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst && push) begin
         mem_inst[tail] <= imem_rsp_data;
         mem_pc[tail]   <= req_pc;
         mem_err[tail]  <= imem_rsp_err;
      end
   end

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// Directed bench for the fetch unit: a simple one-cycle-latency memory
// model driven from tick(), with deliveries to the IDU logged in queues.
module tb_ysyx_25020047_ifu;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        imem_rsp_err = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_err;

   int checks = 0;
   int failures = 0;

   logic        mem_ready = 1'b0;
   logic        rsp_hold = 1'b0;
   logic        pend = 1'b0;
   logic [31:0] pend_addr = '0;
   logic [31:0] err_addr = 32'h1;
   logic        hs_seen = 1'b0;
   int          hs_count = 0;

   logic [31:0] got_pc[$];
   logic [31:0] got_inst[$];
   logic        got_err[$];

   ysyx_25020047_ifu dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .out_pc(out_pc), .out_err(out_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] gp(input int i);
      return (i < got_pc.size()) ? got_pc[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] gi(input int i);
      return (i < got_inst.size()) ? got_inst[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] ge(input int i);
      return (i < got_err.size()) ? {31'd0, got_err[i]} : 32'hDEAD_BEEF;
   endfunction

   task automatic clear_log();
      got_pc.delete();
      got_inst.delete();
      got_err.delete();
   endtask

   // One clock cycle: drive memory side, log handshakes/deliveries, advance.
   task automatic tick();
      logic hs;
      logic rsp;
      logic [31:0] a;
      imem_req_ready = mem_ready;
      rsp            = pend && !rsp_hold;
      imem_rsp_valid = rsp;
      imem_rsp_data  = ~pend_addr;
      imem_rsp_err   = rsp && (pend_addr == err_addr);
      #1;
      hs = imem_req_valid && imem_req_ready;
      a  = imem_req_addr;
      if (rst && !redirect && out_valid && out_ready) begin
         got_pc.push_back(out_pc);
         got_inst.push_back(out_inst);
         got_err.push_back(out_err);
      end
      @(posedge clk);
      #1;
      if (rsp) pend = 1'b0;
      if (hs) begin
         pend      = 1'b1;
         pend_addr = a;
         hs_seen   = 1'b1;
         hs_count++;
      end
   endtask

   task automatic run_until_got(input int n, input string tag);
      int budget = 60;
      while (got_pc.size() < n && budget > 0) begin
         tick();
         budget--;
      end
      if (got_pc.size() < n) check({tag, "_timeout"}, 32'(got_pc.size()), 32'(n));
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      redirect    = 1'b1;
      redirect_pc = pc;
      tick();
      redirect = 1'b0;
      clear_log();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
      check({tag, "_req_addr"},  imem_req_addr,           32'h8000_0000);
      check({tag, "_out_valid"}, {31'd0, out_valid},      32'd0);
      check({tag, "_out_inst"},  out_inst,                32'd0);
      check({tag, "_out_pc"},    out_pc,                  32'd0);
      check({tag, "_out_err"},   {31'd0, out_err},        32'd0);
   endtask

   initial begin
      int budget;
      int hs_before;

      // Reset
      rst = 1'b0;
      repeat (3) tick();
      check_reset_outputs("rst");

      // Streaming fetch
      rst = 1'b1; out_ready = 1'b1; mem_ready = 1'b1;
      run_until_got(3, "stream");
      check("stream_pc0",   gp(0), 32'h8000_0000);
      check("stream_inst0", gi(0), ~32'h8000_0000);
      check("stream_pc1",   gp(1), 32'h8000_0004);
      check("stream_inst1", gi(1), ~32'h8000_0004);
      check("stream_pc2",   gp(2), 32'h8000_0008);
      check("stream_err2",  ge(2), 32'd0);

      // Backpressure: FIFO fills to DEPTH, then requests stop
      out_ready = 1'b0;
      repeat (20) tick();
      check("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_head_pc",   out_pc, 32'h8000_000C);
      clear_log();
      mem_ready = 1'b0; out_ready = 1'b1;
      repeat (4) tick();
      check("drain_count", 32'(got_pc.size()), 32'd2);
      check("drain_pc0",   gp(0), 32'h8000_000C);
      check("drain_pc1",   gp(1), 32'h8000_0010);
      check("drain_req_addr", imem_req_addr, 32'h8000_0014);

      // Redirect with a request outstanding
      mem_ready = 1'b1; rsp_hold = 1'b1; hs_seen = 1'b0;
      budget = 10;
      while (!hs_seen && budget > 0) begin tick(); budget--; end
      check("outstanding_seen", {31'd0, hs_seen}, 32'd1);
      do_redirect(32'h8000_0103);
      check("redir_out_valid", {31'd0, out_valid}, 32'd0);
      check("redir_req_valid", {31'd0, imem_req_valid}, 32'd0);
      rsp_hold = 1'b0;
      run_until_got(2, "redir");
      check("redir_pc0",   gp(0), 32'h8000_0100);
      check("redir_inst0", gi(0), ~32'h8000_0100);
      check("redir_pc1",   gp(1), 32'h8000_0104);

      // Fetch fault halts the front end
      err_addr = 32'h8000_0008;
      do_redirect(32'h8000_0000);
      repeat (16) tick();
      check("fault_count", 32'(got_pc.size()), 32'd3);
      check("fault_err1",  ge(1), 32'd0);
      check("fault_pc2",   gp(2), 32'h8000_0008);
      check("fault_err2",  ge(2), 32'd1);
      hs_before = hs_count;
      repeat (6) tick();
      check("halt_no_req", 32'(hs_count - hs_before), 32'd0);
      check("halt_req_valid", {31'd0, imem_req_valid}, 32'd0);
      err_addr = 32'h1;
      do_redirect(32'h8000_0000);
      run_until_got(1, "resume");
      check("resume_pc0",  gp(0), 32'h8000_0000);
      check("resume_err0", ge(0), 32'd0);

      // Address wrap
      do_redirect(32'hFFFF_FFFC);
      run_until_got(2, "wrap");
      check("wrap_pc0",   gp(0), 32'hFFFF_FFFC);
      check("wrap_pc1",   gp(1), 32'h0000_0000);
      check("wrap_inst1", gi(1), 32'hFFFF_FFFF);

      // Reset in WAIT with a buffered entry, late response afterwards
      out_ready = 1'b0;
      repeat (20) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0; rsp_hold = 1'b1;
      repeat (4) tick();
      check("pre_rst_wait", {31'd0, imem_req_valid}, 32'd0);
      check("pre_rst_buf",  {31'd0, out_valid}, 32'd1);
      check("pre_rst_pend", {31'd0, pend}, 32'd1);
      rst = 1'b0;
      tick();
      check_reset_outputs("rst2");
      rst = 1'b1; rsp_hold = 1'b0;
      clear_log();
      out_ready = 1'b1;
      run_until_got(2, "restart");
      check("restart_pc0",   gp(0), 32'h8000_0000);
      check("restart_inst0", gi(0), ~32'h8000_0000);
      check("restart_pc1",   gp(1), 32'h8000_0004);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
